// File: rtl/masked_hpc3_stream_mul.sv
// Flow-controlled multi-lane HPC3 masked multiplier over GF(2^BIT_WIDTH).
// Share s of lane l is at [(l*NUM_SHARES+s)*BIT_WIDTH +: BIT_WIDTH]; r/p use qindex slots per lane the same way.
module masked_hpc3_stream_mul #(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 4,
  parameter int NUM_LANES  = 1,
  parameter int OUT_REG    = 1
) (
  input  logic                                                        in_clock,
  input  logic                                                        in_reset,
  input  logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0]                   in_a,
  input  logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0]                   in_b,
  input  logic [NUM_LANES*(NUM_SHARES*(NUM_SHARES-1)/2)*BIT_WIDTH-1:0] in_r,
  input  logic [NUM_LANES*(NUM_SHARES*(NUM_SHARES-1)/2)*BIT_WIDTH-1:0] in_p,
  input  logic                                                        in_valid,
  output logic                                                        in_ready,
  output logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0]                   out_c,
  output logic                                                        out_valid,
  input  logic                                                        out_ready
);
  localparam int W  = BIT_WIDTH;
  localparam int NQ = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int NP = NUM_SHARES * (NUM_SHARES - 1);
  localparam int SW = NUM_LANES * NUM_SHARES * W;
  localparam int PW = NUM_LANES * NP * W;
  // Low-order terms of the field polynomial (x^4+x+1 style; AES polynomial for bytes).
  localparam logic [W-1:0] RED = W'((W == 8) ? 32'h1b : ((W == 1) ? 32'h0 : 32'h3));

  function automatic int qindex(input int i, input int j);
    int lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * NUM_SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // Dense slot for the ordered pair (i,j), j != i.
  function automatic int pindex(input int i, input int j);
    return i * (NUM_SHARES - 1) + ((j < i) ? j : j - 1);
  endfunction

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] acc, sh;
    acc = '0;
    sh  = x;
    for (int k = 0; k < W; k++) begin
      if (y[k]) acc = acc ^ sh;
      sh = (sh << 1) ^ (sh[W-1] ? RED : '0);
    end
    return acc;
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic          s1_adv, load;
  logic [SW-1:0] a_q, a_d, c_comb;
  logic [PW-1:0] v_q, v_d, w_q, w_d;
  logic [PW-1:0] v_in, w_in, prod;

  assign in_ready = !s1_valid_q || s1_adv;
  assign load     = in_valid && in_ready;

  for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
    for (genvar gi = 0; gi < NUM_SHARES; gi++) begin : g_share
      for (genvar gj = 0; gj < NUM_SHARES; gj++) begin : g_pair
        if (gj != gi) begin : g_cross
          localparam int  Q       = gl * NQ + qindex(gi, gj);
          localparam int  P       = gl * NP + pindex(gi, gj);
          localparam int  SI      = gl * NUM_SHARES + gi;
          localparam int  SJ      = gl * NUM_SHARES + gj;
          localparam bit  SPECIAL = (gi == 0) ? (gj == 1) : (gj == 0);
          logic [W-1:0] c_ij;
          // The one special partner folds b_i into the correction term.
          assign c_ij = SPECIAL ? (in_b[SI*W +: W] ^ in_r[Q*W +: W]) : in_r[Q*W +: W];
          assign v_in[P*W +: W] = in_r[Q*W +: W] ^ in_b[SJ*W +: W];
          assign w_in[P*W +: W] = in_p[Q*W +: W] ^ gf_mul(in_a[SI*W +: W], c_ij);
          assign prod[P*W +: W] = gf_mul(a_q[SI*W +: W], v_q[P*W +: W]) ^ w_q[P*W +: W];
        end
      end
    end
  end

  always_comb begin
    c_comb = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int i = 0; i < NUM_SHARES; i++)
        for (int j = 0; j < NUM_SHARES; j++)
          if (j != i) c_comb[(l*NUM_SHARES+i)*W +: W] ^= prod[(l*NP+pindex(i, j))*W +: W];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    v_d        = v_q;
    w_d        = w_q;
    if (load) begin
      s1_valid_d = 1'b1;
      a_d        = in_a;
      v_d        = v_in;
      w_d        = w_in;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      v_q        <= '0;
      w_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      v_q        <= v_d;
      w_q        <= w_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic          s2_valid_q, s2_valid_d;
    logic [SW-1:0] c_q, c_d;

    assign s1_adv = !s2_valid_q || out_ready;

    always_comb begin
      s2_valid_d = s2_valid_q;
      c_d        = c_q;
      if (s1_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) c_d = c_comb;
      end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
        s2_valid_q <= 1'b0;
        c_q        <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        c_q        <= c_d;
      end
    end

    assign out_c     = c_q;
    assign out_valid = s2_valid_q;
  end else begin : g_out_comb
    assign s1_adv    = out_ready;
    assign out_c     = c_comb;
    assign out_valid = s1_valid_q;
  end

endmodule

// File: tb/tb_masked_hpc3_stream_mul.sv
// Two instances (d=3 registered output, d=2 combinational output), 2 lanes of GF(16) each,
// checked every cycle against a queue-based model of the unmasked products and handshake timing.
module tb_masked_hpc3_stream_mul;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [23:0] a3, b3, r3, p3;
  logic [15:0] a2, b2;
  logic [7:0]  r2, p2;
  logic [23:0] oc3;
  logic [15:0] oc2;
  logic [1:0]  ir, ov;

  logic [3:0]  ua [2];
  logic [3:0]  ub [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int          head [2];
  int          tail [2];
  int          last_pop [2];
  logic [7:0]  exp_val [2][8];
  int          exp_cyc [2][8];
  logic        prev_stall [2];
  logic [23:0] prev_raw [2];

  masked_hpc3_stream_mul #(
    .NUM_SHARES(3), .BIT_WIDTH(4), .NUM_LANES(2), .OUT_REG(1)
  ) dut_a (
    .in_clock(clk), .in_reset(rst_n),
    .in_a(a3), .in_b(b3), .in_r(r3), .in_p(p3),
    .in_valid(in_valid), .in_ready(ir[0]),
    .out_c(oc3), .out_valid(ov[0]), .out_ready(out_ready)
  );

  masked_hpc3_stream_mul #(
    .NUM_SHARES(2), .BIT_WIDTH(4), .NUM_LANES(2), .OUT_REG(0)
  ) dut_b (
    .in_clock(clk), .in_reset(rst_n),
    .in_a(a2), .in_b(b2), .in_r(r2), .in_p(p2),
    .in_valid(in_valid), .in_ready(ir[1]),
    .out_c(oc2), .out_valid(ov[1]), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^4) mod x^4+x+1: carry-less product, then polynomial long division.
  function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] pr;
    pr = '0;
    for (int i = 0; i < 4; i++) if (y[i]) pr = pr ^ (8'(x) << i);
    for (int k = 7; k >= 4; k--) if (pr[k]) pr = pr ^ (8'h13 << (k - 4));
    return pr[3:0];
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int nsh(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic logic [23:0] raw(input int k);
    return (k == 0) ? oc3 : {8'h00, oc2};
  endfunction

  function automatic logic [7:0] unmask(input int k);
    logic [23:0] rv;
    logic [7:0]  res;
    rv  = raw(k);
    res = '0;
    for (int l = 0; l < 2; l++)
      for (int s = 0; s < nsh(k); s++)
        res[l*4 +: 4] = res[l*4 +: 4] ^ rv[(l*nsh(k)+s)*4 +: 4];
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: random operands, 1: a=3 b=5, 2: a=0 with random b
  task automatic drive(input logic iv, input logic ordy, input int mode);
    logic [3:0] s0, s1, t0, t1;
    for (int l = 0; l < 2; l++) begin
      case (mode)
        1:       begin ua[l] = 4'h3; ub[l] = 4'h5; end
        2:       begin ua[l] = 4'h0; ub[l] = 4'($urandom); end
        default: begin ua[l] = 4'($urandom); ub[l] = 4'($urandom); end
      endcase
      s0 = 4'($urandom); s1 = 4'($urandom);
      t0 = 4'($urandom); t1 = 4'($urandom);
      a3[(l*3+0)*4 +: 4] = s0;
      a3[(l*3+1)*4 +: 4] = s1;
      a3[(l*3+2)*4 +: 4] = ua[l] ^ s0 ^ s1;
      b3[(l*3+0)*4 +: 4] = t0;
      b3[(l*3+1)*4 +: 4] = t1;
      b3[(l*3+2)*4 +: 4] = ub[l] ^ t0 ^ t1;
      s0 = 4'($urandom); t0 = 4'($urandom);
      a2[(l*2+0)*4 +: 4] = s0;
      a2[(l*2+1)*4 +: 4] = ua[l] ^ s0;
      b2[(l*2+0)*4 +: 4] = t0;
      b2[(l*2+1)*4 +: 4] = ub[l] ^ t0;
    end
    r3 = 24'($urandom); p3 = 24'($urandom);
    r2 = 8'($urandom);  p2 = 8'($urandom);
    in_valid  = iv;
    out_ready = ordy;
  endtask

  // Cycle-by-cycle scoreboard: handshakes are resolved on the falling edge before the next rising edge.
  initial begin
    int occ, due_cyc;
    logic due;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          head[k] = 0; tail[k] = 0; last_pop[k] = -100; prev_stall[k] = 1'b0;
        end else begin
          occ = tail[k] - head[k];
          check($sformatf("in_ready dut%0d", k), 32'(ir[k]), 32'((occ < lat(k)) || out_ready));
          due = 1'b0;
          if (occ > 0) begin
            due_cyc = exp_cyc[k][head[k] % 8] + lat(k);
            if (last_pop[k] + 1 > due_cyc) due_cyc = last_pop[k] + 1;
            due = (cyc >= due_cyc);
          end
          check($sformatf("out_valid dut%0d", k), 32'(ov[k]), 32'(due));
          if (ov[k] && occ > 0)
            check($sformatf("product dut%0d", k), 32'(unmask(k)), 32'(exp_val[k][head[k] % 8]));
          if (prev_stall[k])
            check($sformatf("stall_stable dut%0d", k), 32'(raw(k)), 32'(prev_raw[k]));
          if (ov[k] && out_ready && occ > 0) begin
            $display("txn dut%0d #%0d product=%02h cycle=%0d", k, head[k], unmask(k), cyc);
            head[k]++;
            last_pop[k] = cyc;
          end
          if (in_valid && ir[k]) begin
            exp_val[k][tail[k] % 8] = {gmul(ua[1], ub[1]), gmul(ua[0], ub[0])};
            exp_cyc[k][tail[k] % 8] = cyc;
            tail[k]++;
          end
          prev_stall[k] = ov[k] && !out_ready;
          prev_raw[k]   = raw(k);
        end
      end
    end
  end

  initial begin
    logic [15:0] seen_a, seen_b;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a3 = '0; b3 = '0; r3 = '0; p3 = '0;
    a2 = '0; b2 = '0; r2 = '0; p2 = '0;
    ua[0] = '0; ua[1] = '0; ub[0] = '0; ub[1] = '0;

    // Hand-computed GF(16) products pin the reference model.
    check("model 3*5", 32'(gmul(4'h3, 4'h5)), 32'h0f);
    check("model 8*2", 32'(gmul(4'h8, 4'h2)), 32'h03);
    check("model f*f", 32'(gmul(4'hf, 4'hf)), 32'h0a);
    check("model 7*0", 32'(gmul(4'h7, 4'h0)), 32'h00);

    step(); step();
    check("reset out_valid", 32'(ov), 32'h0);
    check("reset in_ready", 32'(ir), 32'h3);
    check("reset out_c a", 32'(oc3), 32'h0);
    check("reset out_c b", 32'(oc2), 32'h0);
    rst_n = 1'b1;

    // Full-rate random stream, with a=0 every eighth transfer.
    for (int i = 0; i < 1000; i++) begin
      step();
      drive(1'b1, 1'b1, (i % 8 == 7) ? 2 : 0);
    end

    // Fixed unmasked operands: the sum stays constant, the shares must not.
    seen_a = '0; seen_b = '0;
    for (int i = 0; i < 100; i++) begin
      step();
      drive(1'b1, 1'b1, 1);
      if (i >= 3 && ov[0]) seen_a = seen_a | (16'h1 << oc3[3:0]);
      if (i >= 3 && ov[1]) seen_b = seen_b | (16'h1 << oc2[3:0]);
    end
    check("share variety a", 32'($countones(seen_a) > 1), 32'h1);
    check("share variety b", 32'($countones(seen_b) > 1), 32'h1);

    // Eight transfers with a four-cycle downstream stall.
    for (int i = 0; i < 12; i++) begin
      step();
      drive(1'(i < 8), 1'(!(i >= 3 && i <= 6)), 0);
    end

    // Random valid/ready toggling.
    for (int i = 0; i < 2000; i++) begin
      step();
      drive(1'($urandom % 2), 1'($urandom % 2), 0);
    end

    // Fill both designs, then reset asynchronously in mid-cycle.
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b1, 1'b0, 0);
    end
    step();
    check("full before reset out_valid", 32'(ov), 32'h3);
    check("full before reset in_ready", 32'(ir), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(ov), 32'h0);
    check("async reset in_ready", 32'(ir), 32'h3);
    check("async reset out_c a", 32'(oc3), 32'h0);
    check("async reset out_c b", 32'(oc2), 32'h0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      drive(1'b0, 1'b1, 0);
    end

    // Short stream after reset, then drain.
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'b1, 1'b1, 0);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      drive(1'b0, 1'b1, 0);
    end
    check("drained dut0", 32'(tail[0] - head[0]), 32'h0);
    check("drained dut1", 32'(tail[1] - head[1]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/masked_hpc3_stream_mul.md
# masked_hpc3_stream_mul

Multi-lane, flow-controlled HPC3 masked multiplier for the masked S-box datapath. It carries NUM_LANES independent d-share products through a registered HPC3 stage, with an optional output register stage. Valid/ready handshakes let the surrounding round pipeline stall without losing or duplicating shares. Every lane computes the same gadget equations. Randomness is consumed only on accepted transfers.

## Interface
- NUM_SHARES, 2, number of shares d (≥2); NUM_QUAD = num_quad(NUM_SHARES) = d(d-1)/2
- BIT_WIDTH, 4, element width; multiplication is generic_mul of that width
- NUM_LANES, 1, independent parallel multipliers (≥1)
- OUT_REG, 1, 1 = registered output stage (latency 2), 0 = outputs driven from stage 1 (latency 1)
- in_clock  in  1  clock, all flops rising-edge
- in_reset  in  1  asynchronous active-low reset
- in_a  in  NUM_LANES×NUM_SHARES×BIT_WIDTH  shares of operand a, per lane
- in_b  in  NUM_LANES×NUM_SHARES×BIT_WIDTH  shares of operand b, per lane
- in_r  in  NUM_LANES×NUM_QUAD×BIT_WIDTH  fresh randomness r, indexed qindex(i,j,NUM_SHARES)
- in_p  in  NUM_LANES×NUM_QUAD×BIT_WIDTH  fresh randomness p, same indexing
- in_valid  in  1  operands and randomness valid
- in_ready  out  1  block accepts this cycle
- out_c  out  NUM_LANES×NUM_SHARES×BIT_WIDTH  product shares
- out_valid  out  1  out_c valid
- out_ready  in  1  downstream accepts out_c

## Operation
- Per lane and share pair i≠j, with q = qindex(i,j) (symmetric in i,j):
  - v_ij = r_q ^ b_j
  - w_ij = p_q ^ a_i·c_ij
  - c_ij = b_i ^ r_q for the one special j per i (j=1 when i=0, j=0 when i≠0); otherwise c_ij = r_q.
- Stage 1 registers a_i, every v_ij and every w_ij. Nothing else is registered in stage 1.
- After stage 1: c_i = XOR over j≠i of (reg_a_i · reg_v_ij ^ reg_w_ij). The XOR of all c_i equals the product of (XOR of a) and (XOR of b).
- Stage 1 controls:
  - s1_valid flag.
  - load = in_valid & in_ready. On load, all stage-1 data registers of all lanes capture together.
  - Data registers hold when not loaded. They never capture partial or invalid data into a held valid slot.
  - in_ready = !s1_valid | s1_adv.
- OUT_REG=1:
  - Stage 2 registers c and s2_valid.
  - s1_adv = !s2_valid | out_ready. On s1_adv, s2 captures c and s2_valid ← s1_valid.
  - out_c and out_valid are driven from stage 2.
- OUT_REG=0:
  - out_c = c, out_valid = s1_valid, s1_adv = out_ready.
- s1_valid next state:
  - ← 1 on load.
  - ← 0 when s1_adv & !load.
  - Holds otherwise.
- Randomness on in_r/in_p is sampled only on load. The bench must supply fresh randomness per accepted transfer; the block does not check this.
- Shares of different indices are never combined before a register, except in the defined per-share products above.

## Timing
- Reset (in_reset=0, asynchronous):
  - s1_valid = s2_valid = 0 and all data registers = 0.
  - Outputs: out_valid=0, out_c=0, in_ready=1.
  - Release is synchronous to the next in_clock edge.
- Latency from load edge to out_valid high:
  - OUT_REG=1: 2 cycles.
  - OUT_REG=0: 1 cycle.
- Throughput is one transfer per cycle while out_ready=1.
- in_ready depends combinationally on out_ready. There is no skid buffer.
- Backpressure:
  - out_valid and out_c remain stable while out_valid & !out_ready.
  - With OUT_REG=1, stage 1 still fills when stage 2 is full. in_ready drops only when both stages are full and out_ready=0.
- Simultaneous pop and load in the same cycle on a full stage: both occur, and no bubble is inserted.
- in_valid=1 while in_ready=0: no capture. The upstream holds its data (AXI-style). The block does not require in_valid to stay stable.
- Reset mid-operation: all in-flight products are discarded, and no out_valid pulse follows reset release.

## Test plan
- Reset: assert in_reset=0 mid-stream with both stages full → out_valid=0, out_c=0, in_ready=1 immediately. No output after release until a new load.
- Functional: NUM_SHARES=2,3, BIT_WIDTH=4, NUM_LANES=2, OUT_REG=1, 1000 random a,b,r,p → unmasked out_c equals the generic_mul model per lane, out_valid exactly 2 cycles after each load. Also a=0 → unmasked result 0 for any b, r, p.
- Masking sanity: fix unmasked a=0x3, b=0x5 across 100 transfers with random sharings and randomness → unmasked result constant, individual out_c shares vary.
- Backpressure: OUT_REG=1, stream 8 transfers, out_ready=0 for cycles 3–6 → in_ready=0 only when both stages are full, out_c stable while stalled, all 8 results in order with no loss or duplication.
- Full-throughput pop+push: out_ready=1 and in_valid=1 for 16 cycles → 16 results on consecutive cycles. Repeat with OUT_REG=0 → latency 1 cycle, in_ready equals out_ready when s1_valid=1.
- Random in_valid/out_ready toggling (50%) over 2000 cycles → scoreboard matches in order, in_r/in_p changes outside load cycles do not affect results.
